// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle two's-complement subtractor, one chunk-wide
// slice per clock, with unsigned borrow and signed overflow flags.
module seq_subtractor #(
    parameter int width = 32,
    parameter int chunk = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] Out,
    output logic             Bout,
    output logic             overflow
);

    localparam int N  = width / chunk;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [width-1:0] a_q, b_q, out_q;
    logic             carry_q, bout_q, ovf_q;
    logic [IW-1:0]    idx_q;

    logic             accept, last, cin_msb;
    logic [chunk-1:0] a_sl, nb_sl;
    logic [chunk:0]   sum;

    assign accept = start && (state_q != RUN);
    assign last   = (idx_q == IW'(N - 1));
    assign a_sl   = a_q[idx_q*chunk +: chunk];
    assign nb_sl  = ~b_q[idx_q*chunk +: chunk];
    assign sum    = {1'b0, a_sl} + {1'b0, nb_sl} + {{chunk{1'b0}}, carry_q};

    // Recover the carry into the slice MSB from its sum bit: s = a ^ b ^ cin.
    assign cin_msb = sum[chunk-1] ^ a_sl[chunk-1] ^ nb_sl[chunk-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        Out      = out_q;
        Bout     = bout_q;
        overflow = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= 1'b1;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            out_q[idx_q*chunk +: chunk] <= sum[chunk-1:0];
            carry_q <= sum[chunk];
            idx_q   <= idx_q + IW'(1);
            if (last) begin
                bout_q <= ~sum[chunk];
                ovf_q  <= cin_msb ^ sum[chunk];
            end
        end
    end

endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench for seq_subtractor: directed corner cases plus random
// operands checked against a plain-arithmetic reference model.
module tb_seq_subtractor;

    typedef struct {
        logic [31:0] out;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] Out;
    logic        Bout, overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    seq_subtractor #(.width(32), .chunk(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Out(Out), .Bout(Bout),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b);
        exp_t   r;
        longint sd;
        r.out  = a - b;
        r.bout = (a < b);
        sd     = longint'($signed(a)) - longint'($signed(b));
        r.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return r;
    endfunction

    function automatic exp_t mk(logic [31:0] o, logic bo, logic ov);
        exp_t r;
        r.out  = o;
        r.bout = bo;
        r.ovf  = ov;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_twice actual=1 required=0");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                if (Out !== e.out || Bout !== e.bout || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL result actual=%h/%b/%b required=%h/%b/%b",
                             Out, Bout, overflow, e.out, e.bout, e.ovf);
                end
            end
        end
        prev_done = rst_n && done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Issue one op from a negedge with the DUT not in RUN; wait for done.
    task automatic do_op(logic [31:0] a, logic [31:0] b, exp_t e,
                         output int lat, output int bc);
        bit found = 0;
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(e);
        lat = 0;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bc++;
            if (done) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout actual=none required=done");
        end
    endtask

    function automatic logic [31:0] pick();
        unique case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, bc, ndone, last_cyc;
        logic [31:0] a, b;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", Out, 0);
        chk("rst_flags", {busy, done, Bout, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd5, 32'd3, mk(32'h2, 0, 0), lat, bc);
        chk("latency", lat, 5);
        chk("busy_cycles", bc, 4);
        do_op(32'd3, 32'd5, mk(32'hFFFF_FFFE, 1, 0), lat, bc);
        do_op(32'd0, 32'd0, mk(32'h0, 0, 0), lat, bc);
        do_op(32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 0, 1), lat, bc);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, mk(32'h8000_0000, 1, 1), lat, bc);

        // Start during RUN must be ignored.
        repeat (3) @(negedge clk);
        A = 32'd10;
        B = 32'd4;
        start = 1'b1;
        sb.push_back(mk(32'd6, 0, 0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 32'd1;
        B = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignored_start_sb", sb.size(), 0);

        // Start held high; new operands each DONE, junk operands while busy.
        ndone = 0;
        last_cyc = 0;
        A = $urandom;
        B = $urandom;
        start = 1'b1;
        sb.push_back(model(A, B));
        for (int cyc = 1; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone > 1) chk("b2b_spacing", cyc - last_cyc, 5);
                last_cyc = cyc;
                if (ndone < 6) begin
                    A = pick();
                    B = $urandom_range(0, 1) ? A : pick();
                    sb.push_back(model(A, B));
                end else begin
                    start = 1'b0;
                    break;
                end
            end else if (busy) begin
                A = $urandom;
                B = $urandom;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 6);

        // Reset in the middle of RUN.
        do_op(32'd3, 32'd5, mk(32'hFFFF_FFFE, 1, 0), lat, bc);
        A = $urandom;
        B = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("hold_flags", {Bout, overflow}, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", Out, 0);
        chk("midrst_flags", {busy, done, Bout, overflow}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        do_op(32'h1234_5678, 32'h0101_0101, mk(32'h1133_5577, 0, 0), lat, bc);

        for (int i = 0; i < 150; i++) begin
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? a : pick();
            do_op(a, b, model(a, b), lat, bc);
            chk("rand_latency", lat, 5);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
